// File: rtl/mult_pkg.sv
// Shared constants and encodings for the sequential Booth multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Radix-2 recode of {q[0], q_m1}: 01 adds M, 10 subtracts M.
  function automatic booth_op_t booth_decode(input logic [1:0] bits);
    case (bits)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: recode, add/sub into acc, arithmetic shift of P.
// P layout is {acc[WIDTH:0], q[WIDTH-1:0], q_m1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2*WIDTH+1:0] p_in,
  input  logic [WIDTH:0]     m_in,
  output logic [2*WIDTH+1:0] p_out
);

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   sum;
  booth_op_t        op;

  assign acc  = p_in[2*WIDTH+1:WIDTH+1];
  assign q    = p_in[WIDTH:1];
  assign q_m1 = p_in[0];
  assign op   = booth_decode({q[0], q_m1});

  // Add/subtract the multiplicand, then shift right replicating acc's sign.
  // Old q_m1 falls off; old q[0] becomes the new q_m1.
  always_comb begin
    sum = acc;
    case (op)
      BOOTH_ADD: sum = acc + m_in;
      BOOTH_SUB: sum = acc - m_in;
      default:   sum = acc;
    endcase
    p_out = {sum[WIDTH], sum, q};
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTH x WIDTH multiplier, radix-2 Booth, one iteration
// per clock. Result appears on hi/lo WIDTH cycles after the accepting edge.
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH + 2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic [PW-1:0]    p_next;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p_q),
    .m_in  (m_q),
    .p_out (p_next)
  );

  // Next-state: accept in IDLE, iterate in RUN, publish result on last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          p_d     = {{(WIDTH+1){1'b0}}, B, 1'b0};
          m_d     = {A[WIDTH-1], A};
        end
      end
      RUN: begin
        p_d   = p_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = IDLE;
          hi_d    = p_next[2*WIDTH:WIDTH+1];
          lo_d    = p_next[WIDTH:1];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
